// File: rtl/kamacore_pkg.sv
// Shared kamacore pipeline definitions: RV32I opcodes, load funct3 codes,
// datapath widths and writeback source decode.
package kamacore_pkg;

   localparam int unsigned CPU_WIDTH      = 32;
   localparam int unsigned REG_ADDR_WIDTH = 5;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LOAD, WB_LINK} wb_src_t;

   function automatic wb_src_t decode_wb_src(input logic [6:0] opc);
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: return WB_ALU;
         OPC_LOAD:                               return WB_LOAD;
         OPC_JAL, OPC_JALR:                      return WB_LINK;
         default:                                return WB_NONE;
      endcase
   endfunction

   function automatic logic is_load_f3(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

endpackage

// File: rtl/kamacore_stage_wb_if.sv
// MEM/WB entry into the writeback stage and the register-file write port it drives.
interface kamacore_stage_wb_if #(
   parameter int unsigned CPU_WIDTH      = kamacore_pkg::CPU_WIDTH,
   parameter int unsigned REG_ADDR_WIDTH = kamacore_pkg::REG_ADDR_WIDTH
) ();

   logic                      wb_valid;
   logic [31:0]               wb_instruction;
   logic [CPU_WIDTH-1:0]      wb_alu_result;
   logic [CPU_WIDTH-1:0]      wb_mem_rdata;
   logic [CPU_WIDTH-1:0]      wb_pc_plus4;

   logic                      writeback_rd_we;
   logic [REG_ADDR_WIDTH-1:0] writeback_rd_a;
   logic [CPU_WIDTH-1:0]      writeback_rd_data;

   modport master (
      output wb_valid, wb_instruction, wb_alu_result, wb_mem_rdata, wb_pc_plus4,
      input  writeback_rd_we, writeback_rd_a, writeback_rd_data
   );

   modport slave (
      input  wb_valid, wb_instruction, wb_alu_result, wb_mem_rdata, wb_pc_plus4,
      output writeback_rd_we, writeback_rd_a, writeback_rd_data
   );

endinterface

// File: rtl/kamacore_load_extract.sv
// Extracts and extends a byte/half/word from an aligned memory word and
// flags naturally misaligned accesses. Shared with the memory stage.
module kamacore_load_extract
   import kamacore_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data,
   output logic        misaligned
);

   logic [31:0] shifted;

   assign shifted = rdata >> {off, 3'b000};

   always_comb begin
      data       = '0;
      misaligned = 1'b0;
      case (funct3)
         F3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LBU: data = {24'd0, shifted[7:0]};
         F3_LH: begin
            data       = {{16{shifted[15]}}, shifted[15:0]};
            misaligned = off[0];
         end
         F3_LHU: begin
            data       = {16'd0, shifted[15:0]};
            misaligned = off[0];
         end
         F3_LW: begin
            data       = rdata;
            misaligned = (off != 2'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/kamacore_stage_wb.sv
// kamacore writeback stage: selects the retiring result, drives the register-file
// write port, counts retired instructions and flags misaligned loads.
module kamacore_stage_wb #(
   parameter int unsigned CPU_WIDTH      = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned INSTRET_WIDTH  = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   kamacore_stage_wb_if.slave       wb,
   output logic                     load_misaligned,
   output logic [INSTRET_WIDTH-1:0] instret
);

   import kamacore_pkg::*;

   logic [6:0]                opc;
   logic [2:0]                f3;
   logic [REG_ADDR_WIDTH-1:0] rd;
   wb_src_t                   src;
   logic [CPU_WIDTH-1:0]      ld_data;
   logic                      ld_mis;
   logic                      fire;
   logic                      we_d;
   logic                      mis_d;
   logic [CPU_WIDTH-1:0]      data_d;
   logic                      unused_instr_hi;

   assign opc             = wb.wb_instruction[6:0];
   assign rd              = wb.wb_instruction[11:7];
   assign f3              = wb.wb_instruction[14:12];
   assign unused_instr_hi = ^wb.wb_instruction[31:15];

   kamacore_load_extract u_load_extract (
      .rdata      (wb.wb_mem_rdata),
      .off        (wb.wb_alu_result[1:0]),
      .funct3     (f3),
      .data       (ld_data),
      .misaligned (ld_mis)
   );

   always_comb begin
      src    = decode_wb_src(opc);
      fire   = wb.wb_valid && !stall;
      we_d   = 1'b0;
      mis_d  = 1'b0;
      data_d = wb.wb_alu_result;
      case (src)
         WB_ALU:  we_d = (rd != '0);
         WB_LINK: begin
            we_d   = (rd != '0);
            data_d = wb.wb_pc_plus4;
         end
         WB_LOAD: begin
            // Unsupported funct3 neither writes nor flags; the flag ignores rd.
            mis_d  = is_load_f3(f3) && ld_mis;
            we_d   = (rd != '0) && is_load_f3(f3) && !ld_mis;
            data_d = ld_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb.writeback_rd_we   <= 1'b0;
         wb.writeback_rd_a    <= '0;
         wb.writeback_rd_data <= '0;
         load_misaligned      <= 1'b0;
         instret              <= '0;
      end else begin
         wb.writeback_rd_we <= 1'b0;
         load_misaligned    <= 1'b0;
         if (fire) begin
            wb.writeback_rd_we   <= we_d;
            load_misaligned      <= mis_d;
            wb.writeback_rd_a    <= rd;
            wb.writeback_rd_data <= data_d;
            instret              <= instret + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_kamacore_stage_wb.sv
// Self-checking bench for kamacore_stage_wb: vector table through a scoreboard,
// plus reset, stall and counter-wrap sequences.
module tb_kamacore_stage_wb;

   typedef struct {
      string       nm;
      logic        stall;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc4;
      logic        we;
      logic [4:0]  a;
      logic [31:0] data;
      logic        mis;
      logic        chk_ad;
   } vec_t;

   typedef struct {
      string       nm;
      logic        we;
      logic [4:0]  a;
      logic [31:0] data;
      logic        mis;
      logic        chk_ad;
      logic [63:0] instret;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        mis;
   logic [63:0] instret;
   logic        mis2;
   logic [3:0]  instret2;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [63:0] model_instret = '0;
   exp_t        sb[$];
   vec_t        vecs[$];

   kamacore_stage_wb_if #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5)) wif ();
   kamacore_stage_wb_if #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5)) wif2 ();

   kamacore_stage_wb #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5), .INSTRET_WIDTH(64)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .wb              (wif.slave),
      .load_misaligned (mis),
      .instret         (instret)
   );

   kamacore_stage_wb #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5), .INSTRET_WIDTH(4)) dut_wrap (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .wb              (wif2.slave),
      .load_misaligned (mis2),
      .instret         (instret2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [2:0] f3);
      return {17'd0, f3, rd, opc};
   endfunction

   function automatic vec_t mk(input string nm, input logic st, input logic v,
                               input logic [31:0] instr, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic [31:0] pc4,
                               input logic we, input logic [4:0] a,
                               input logic [31:0] data, input logic m, input logic ca);
      vec_t r;
      r.nm = nm; r.stall = st; r.valid = v; r.instr = instr; r.alu = alu;
      r.rdata = rdata; r.pc4 = pc4; r.we = we; r.a = a; r.data = data;
      r.mis = m; r.chk_ad = ca;
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      stall               = v.stall;
      wif.wb_valid        = v.valid;
      wif.wb_instruction  = v.instr;
      wif.wb_alu_result   = v.alu;
      wif.wb_mem_rdata    = v.rdata;
      wif.wb_pc_plus4     = v.pc4;
      if (v.valid && !v.stall) model_instret = model_instret + 64'd1;
      e.nm = v.nm; e.we = v.we; e.a = v.a; e.data = v.data; e.mis = v.mis;
      e.chk_ad = v.chk_ad; e.instret = model_instret;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check({e.nm, ".we"}, {63'd0, wif.writeback_rd_we}, {63'd0, e.we});
         check({e.nm, ".mis"}, {63'd0, mis}, {63'd0, e.mis});
         check({e.nm, ".instret"}, instret, e.instret);
         if (e.chk_ad) begin
            check({e.nm, ".rd_a"}, {59'd0, wif.writeback_rd_a}, {59'd0, e.a});
            check({e.nm, ".rd_data"}, {32'd0, wif.writeback_rd_data}, {32'd0, e.data});
         end
      end
   endtask

   localparam logic [6:0] T_OP_IMM = 7'h13, T_LOAD = 7'h03, T_STORE = 7'h23,
                          T_JAL = 7'h6F, T_OP = 7'h33, T_LUI = 7'h37, T_BRANCH = 7'h63;
   localparam logic [31:0] RD_W = 32'h80FF_1234;

   initial begin
      rst = 1'b0; stall = 1'b0;
      wif.wb_valid = 1'b0; wif.wb_instruction = '0; wif.wb_alu_result = '0;
      wif.wb_mem_rdata = '0; wif.wb_pc_plus4 = '0;
      wif2.wb_valid = 1'b0; wif2.wb_instruction = enc(T_OP_IMM, 5'd1, 3'd0);
      wif2.wb_alu_result = '0; wif2.wb_mem_rdata = '0; wif2.wb_pc_plus4 = '0;

      // Vector table
      vecs.push_back(mk("addi_x5",   0, 1, enc(T_OP_IMM, 5, 0), 32'h2A,   RD_W, 0, 1, 5,  32'h2A,       0, 1));
      vecs.push_back(mk("addi_x0",   0, 1, enc(T_OP_IMM, 0, 0), 32'h2A,   RD_W, 0, 0, 0,  0,            0, 0));
      vecs.push_back(mk("lb_1003",   0, 1, enc(T_LOAD, 10, 0),  32'h1003, RD_W, 0, 1, 10, 32'hFFFF_FF80, 0, 1));
      vecs.push_back(mk("lbu_1003",  0, 1, enc(T_LOAD, 11, 4),  32'h1003, RD_W, 0, 1, 11, 32'h0000_0080, 0, 1));
      vecs.push_back(mk("lh_1002",   0, 1, enc(T_LOAD, 12, 1),  32'h1002, RD_W, 0, 1, 12, 32'hFFFF_80FF, 0, 1));
      vecs.push_back(mk("lhu_1002",  0, 1, enc(T_LOAD, 13, 5),  32'h1002, RD_W, 0, 1, 13, 32'h0000_80FF, 0, 1));
      vecs.push_back(mk("lb_1002",   0, 1, enc(T_LOAD, 14, 0),  32'h1002, RD_W, 0, 1, 14, 32'hFFFF_FFFF, 0, 1));
      vecs.push_back(mk("lh_1000",   0, 1, enc(T_LOAD, 19, 1),  32'h1000, RD_W, 0, 1, 19, 32'h0000_1234, 0, 1));
      vecs.push_back(mk("lw_1000",   0, 1, enc(T_LOAD, 15, 2),  32'h1000, RD_W, 0, 1, 15, 32'h80FF_1234, 0, 1));
      vecs.push_back(mk("lw_1002",   0, 1, enc(T_LOAD, 16, 2),  32'h1002, RD_W, 0, 0, 0,  0,            1, 0));
      vecs.push_back(mk("lh_1003",   0, 1, enc(T_LOAD, 17, 1),  32'h1003, RD_W, 0, 0, 0,  0,            1, 0));
      vecs.push_back(mk("lbu_1001",  0, 1, enc(T_LOAD, 3, 4),   32'h1001, RD_W, 0, 1, 3,  32'h0000_0012, 0, 1));
      vecs.push_back(mk("ld_f3_3",   0, 1, enc(T_LOAD, 18, 3),  32'h1000, RD_W, 0, 0, 0,  0,            0, 0));
      vecs.push_back(mk("jal_x1",    0, 1, enc(T_JAL, 1, 0),    32'h0,    RD_W, 32'h104, 1, 1, 32'h104, 0, 1));
      vecs.push_back(mk("bubble",    0, 0, enc(T_OP_IMM, 9, 0), 32'h77,   RD_W, 0, 0, 1,  32'h104,      0, 1));
      vecs.push_back(mk("sw",        0, 1, enc(T_STORE, 5, 2),  32'h1000, RD_W, 0, 0, 0,  0,            0, 0));
      vecs.push_back(mk("lui_x7",    0, 1, enc(T_LUI, 7, 0),    32'hABCD_E000, RD_W, 0, 1, 7, 32'hABCD_E000, 0, 1));
      vecs.push_back(mk("branch",    0, 1, enc(T_BRANCH, 4, 0), 32'h0,    RD_W, 0, 0, 0,  0,            0, 0));
      vecs.push_back(mk("add_x7_a",  0, 1, enc(T_OP, 7, 0),     32'h1,    RD_W, 0, 1, 7,  32'h1,        0, 1));
      vecs.push_back(mk("add_x7_b",  0, 1, enc(T_OP, 7, 0),     32'h2,    RD_W, 0, 1, 7,  32'h2,        0, 1));
      vecs.push_back(mk("stall_lw",  1, 1, enc(T_LOAD, 16, 2),  32'h1002, RD_W, 0, 0, 7,  32'h2,        0, 1));
      vecs.push_back(mk("idle",      0, 0, enc(T_LOAD, 16, 2),  32'h1002, RD_W, 0, 0, 7,  32'h2,        0, 1));

      // Reset state
      #12;
      check("reset.we", {63'd0, wif.writeback_rd_we}, 64'd0);
      check("reset.instret", instret, 64'd0);
      check("reset.rd_data", {32'd0, wif.writeback_rd_data}, 64'd0);
      rst = 1'b1;

      // Mid-run asynchronous reset after five retirements
      for (int i = 0; i < 5; i++) begin
         drive(mk("pre_addi", 0, 1, enc(T_OP_IMM, 6, 0), 32'h10 + i, RD_W, 0, 1, 6, 32'h10 + i, 0, 1));
         tick();
      end
      check("pre_reset.instret", instret, 64'd5);
      wif.wb_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("async_reset.we", {63'd0, wif.writeback_rd_we}, 64'd0);
      check("async_reset.rd_a", {59'd0, wif.writeback_rd_a}, 64'd0);
      check("async_reset.rd_data", {32'd0, wif.writeback_rd_data}, 64'd0);
      check("async_reset.instret", instret, 64'd0);
      #2 rst = 1'b1;
      model_instret = '0;
      drive(mk("post_reset_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tick();

      foreach (vecs[i]) begin
         drive(vecs[i]);
         tick();
      end

      // Held entry under stall retires exactly once
      for (int i = 0; i < 3; i++) begin
         drive(mk("stall_add", 1, 1, enc(T_OP, 9, 0), 32'h55, RD_W, 0, 0, 7, 32'h2, 0, 1));
         tick();
      end
      drive(mk("release_add", 0, 1, enc(T_OP, 9, 0), 32'h55, RD_W, 0, 1, 9, 32'h55, 0, 1));
      tick();
      drive(mk("after_add", 0, 0, enc(T_OP, 9, 0), 32'h55, RD_W, 0, 0, 9, 32'h55, 0, 1));
      tick();

      // Counter wrap on a narrow instance
      wif.wb_valid  = 1'b0;
      wif2.wb_valid = 1'b1;
      for (int i = 0; i < 15; i++) @(posedge clk);
      #1 check("wrap.all_ones", {60'd0, instret2}, 64'd15);
      @(posedge clk);
      #1 check("wrap.zero", {60'd0, instret2}, 64'd0);
      wif2.wb_valid = 1'b0;
      check("wrap.main_idle", instret, model_instret);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
